// File: rtl/dso_wave_reader_if.sv
// Bundle of the frame-read control, capture-RAM read port and output byte stream
// used by dso_wave_reader. The reader drives the RAM port and the stream (master);
// the capture RAM / display side is the slave.
interface dso_wave_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] wave_rd_addr;
  logic [DATA_W-1:0] wave_rd_data;
  logic              ram_rd_over;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [DATA_W-1:0] frame_max;
  logic [DATA_W-1:0] frame_min;

  modport master (
    input  start, abort, wave_rd_data, out_ready,
    output busy, done, ram_rd_en, wave_rd_addr, ram_rd_over,
           out_valid, out_data, out_last, frame_max, frame_min
  );

  modport slave (
    output start, abort, wave_rd_data, out_ready,
    input  busy, done, ram_rd_en, wave_rd_addr, ram_rd_over,
           out_valid, out_data, out_last, frame_max, frame_min
  );
endinterface

// File: rtl/dso_wave_reader.sv
// Read-side controller for the oscilloscope capture RAM. Sweeps one frame of
// H_POINTS samples out of the RAM, buffers them in a 4-entry FIFO behind a
// credit check, streams them on a valid/ready byte stream and reports the
// frame min/max once the whole frame has been read.
module dso_wave_reader #(
  parameter int H_POINTS = 640,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  dso_wave_reader_if.master  bus_if
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_POINTS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic              cap_v_q;
  logic              cap_last_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_over_q;
  logic [DATA_W-1:0] run_max_q;
  logic [DATA_W-1:0] run_min_q;
  logic [DATA_W-1:0] frame_max_q;
  logic [DATA_W-1:0] frame_min_q;

  logic [DATA_W-1:0] fifo_data_q [4];
  logic              fifo_last_q [4];
  logic [1:0]        wr_ptr_q;
  logic [1:0]        rd_ptr_q;
  logic [2:0]        count_q;

  logic              flush;
  logic              push;
  logic              pop;
  logic              issue;
  logic              head_last;
  logic [2:0]        credit;
  logic [2:0]        count_d;
  logic [DATA_W-1:0] run_max_d;
  logic [DATA_W-1:0] run_min_d;

  // Handshake decode, read credit (buffered + in flight) and running min/max candidates
  always_comb begin
    flush     = bus_if.abort && (state_q != IDLE);
    push      = cap_v_q;
    pop       = (count_q != 3'd0) && bus_if.out_ready;
    head_last = fifo_last_q[rd_ptr_q];
    credit    = count_q + 3'(rd_en_q) + 3'(cap_v_q);
    issue     = (state_q == READ) && (credit < 3'd4);
    count_d   = count_q + 3'(push) - 3'(pop);
    run_max_d = (bus_if.wave_rd_data > run_max_q) ? bus_if.wave_rd_data : run_max_q;
    run_min_d = (bus_if.wave_rd_data < run_min_q) ? bus_if.wave_rd_data : run_min_q;
  end

  // Frame FSM with read issue, capture pipeline tag and min/max tracking
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      cap_v_q     <= 1'b0;
      cap_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_over_q   <= 1'b0;
      run_max_q   <= '0;
      run_min_q   <= '1;
      frame_max_q <= '0;
      frame_min_q <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      cap_v_q    <= 1'b0;
      cap_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_over_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_over_q  <= 1'b0;
      cap_v_q    <= rd_en_q;
      cap_last_q <= rd_en_q && (addr_q == LAST_ADDR);
      if (cap_v_q) begin
        run_max_q <= run_max_d;
        run_min_q <= run_min_d;
        if (cap_last_q) begin
          rd_over_q   <= 1'b1;
          frame_max_q <= run_max_d;
          frame_min_q <= run_min_d;
        end
      end
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          if (bus_if.start && !bus_if.abort) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            addr_q    <= '0;
            cnt_q     <= ADDR_W'(1);
            run_max_q <= '0;
            run_min_q <= '1;
          end
        end
        READ: begin
          if (issue) begin
            rd_en_q <= 1'b1;
            addr_q  <= cnt_q;
            cnt_q   <= cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          rd_en_q <= 1'b0;
          if (pop && head_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Four-entry sample FIFO; a simultaneous push and pop on a full FIFO is safe
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 4; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus_if.wave_rd_data;
        fifo_last_q[wr_ptr_q] <= cap_last_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end

  assign bus_if.busy         = busy_q;
  assign bus_if.done         = done_q;
  assign bus_if.ram_rd_en    = rd_en_q;
  assign bus_if.wave_rd_addr = addr_q;
  assign bus_if.ram_rd_over  = rd_over_q;
  assign bus_if.out_valid    = (count_q != 3'd0);
  assign bus_if.out_data     = fifo_data_q[rd_ptr_q];
  assign bus_if.out_last     = head_last;
  assign bus_if.frame_max    = frame_max_q;
  assign bus_if.frame_min    = frame_min_q;

endmodule

// File: doc/dso_wave_reader.md
# dso_wave_reader

Read-side controller for the oscilloscope capture RAM. On a start pulse it sweeps one display frame of `H_POINTS` samples out of the capture buffer, driving `ram_rd_en` and `wave_rd_addr` and consuming `wave_rd_data`. It then pulses `ram_rd_over` so the capture side re-arms. Samples leave on a valid/ready byte stream with frame-end marking and per-frame min/max, feeding the display/host link in the `ram_rd_clk` domain.

## Interface
- `H_POINTS`, 640: samples per frame; range 2..1024.
- `ADDR_W`, 10: width of `wave_rd_addr`.
- `DATA_W`, 8: sample width.
- `clk`  in  1  read-domain clock, the same clock as `ram_rd_clk` of the capture block.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to read a frame; ignored while `busy`=1.
- `abort`  in  1  one-cycle request to cancel the current frame.
- `busy`  out  1  high from the accepted `start` until `done` or abort.
- `done`  out  1  one-cycle pulse after the last output beat is accepted.
- `ram_rd_en`  out  1  RAM read strobe.
- `wave_rd_addr`  out  ADDR_W  RAM read address.
- `wave_rd_data`  in  DATA_W  RAM data; valid in the cycle after the `ram_rd_en` cycle.
- `ram_rd_over`  out  1  one-cycle pulse: the whole frame has been read from the RAM.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_data`  out  DATA_W  sample.
- `out_last`  out  1  high with the beat carrying sample `H_POINTS-1`.
- `frame_max`  out  DATA_W  maximum of the last completed frame.
- `frame_min`  out  DATA_W  minimum of the last completed frame.

## Operation
- The FSM has 3 states: IDLE, READ, DRAIN.
- IDLE: when `start`=1, go to READ, clear the address counter, and load the running max with 0 and the running min with all-ones.
- READ: issue one read per cycle while FIFO occupancy plus in-flight reads (up to 2) is less than 4.
  - An issue registers `ram_rd_en`=1 and `wave_rd_addr`=counter, and increments the counter.
  - Otherwise `ram_rd_en`=0 and `wave_rd_addr` holds its value.
  - After issuing address `H_POINTS-1`, go to DRAIN.
- Capture path:
  - One cycle after `ram_rd_en`=1, `wave_rd_data` is written into a 4-entry FIFO, tagged `last` when its address equals `H_POINTS-1`.
  - The running max/min update on every capture.
- DRAIN: when the `last` sample is captured, pulse `ram_rd_over` on the next cycle and latch the running max/min into `frame_max`/`frame_min` on the same cycle. Stay in DRAIN until the beat with `out_last`=1 handshakes; then pulse `done`, return to IDLE, and drop `busy`.
- Stream:
  - `out_valid` = FIFO not empty; `out_data`/`out_last` = FIFO head.
  - A beat transfers when `out_valid`&`out_ready`.
  - While `out_valid`=1, `out_data`/`out_last` are stable until the beat transfers.
  - A write and a read in the same cycle on a full FIFO is legal; the credit rule guarantees no overflow.
- `abort` (any state except IDLE):
  - Next cycle: IDLE, FIFO flushed, `out_valid`=0, `ram_rd_en`=0, `busy`=0.
  - Data for reads still in flight is discarded.
  - No `ram_rd_over`, no `done`; `frame_max`/`frame_min` unchanged.
- `abort` and `start` in the same cycle: `abort` wins and `start` is dropped.
- `start` while `busy`: ignored, no side effects.
- Reset values: `busy`, `done`, `ram_rd_en`, `ram_rd_over`, `out_valid`, `out_last` = 0; `wave_rd_addr`, `out_data`, `frame_max`, `frame_min` = 0; FIFO empty; state IDLE.
- Asserting `rstn` mid-frame returns immediately to the reset values; the frame is lost.

## Timing
- All outputs are registered except `out_valid`/`out_data`/`out_last`, which come directly from FIFO head registers.
- Cycle numbering, with `start` sampled at edge E:
  - E+1: `busy`=1; `ram_rd_en`=1 with address 0.
  - E+2: sample 0 captured.
  - E+3: `out_valid`=1. First-beat latency is 3 cycles.
- Throughput with `out_ready` held at 1: one sample per cycle, no bubbles.
  - Address k is issued at E+1+k.
  - `ram_rd_over` is high in cycle E+H_POINTS+2.
  - The last beat is available at E+H_POINTS+2; `done` pulses at E+H_POINTS+3.
- Backpressure: with `out_ready`=0, at most 4 samples are buffered and no further reads issue until space frees. Reads resume in the cycle after space frees.
- `ram_rd_over` is never asserted for more than one cycle per frame.

## Test plan
- Fill the RAM model with `data=addr[7:0]`, `H_POINTS`=640, `out_ready`=1, pulse `start` → 640 beats of 0..255,0..255,0..127; `out_last` only on beat 639; `ram_rd_over` pulse at E+642; `done` at E+643; `frame_max`=255, `frame_min`=0.
- Same frame with `out_ready` toggling 1,0,0 → identical data order; `ram_rd_en` never causes more than 4 buffered samples; FIFO never overflows; `out_data` stable while stalled.
- Fill the RAM with a sine of 128±100 → `frame_max`=228, `frame_min`=28, latched in the `ram_rd_over` cycle; values before that stay from the previous frame.
- `abort` at beat 300 → `out_valid`=0 the next cycle; `ram_rd_over` and `done` never pulse; a new `start` reads from address 0.
- `start` pulsed at beat 100 of a running frame → ignored; frame completes normally with exactly 640 beats.
- Deassert `rstn` at beat 50 → every output returns to its reset value asynchronously; after release, `start` yields a clean frame.
